// File: rtl/test_status_monitor_pkg.sv
// Shared types for the end-of-test status monitor: FSM encoding, default
// register indices and shadow-register slot numbering.
package test_status_monitor_pkg;

  typedef enum logic [2:0] {
    TSM_IDLE   = 3'd0,
    TSM_RUN    = 3'd1,
    TSM_SETTLE = 3'd2,
    TSM_PASS   = 3'd3,
    TSM_FAIL   = 3'd4,
    TSM_TO     = 3'd5
  } tsm_state_e;

  // rv32ui-p-* conventions: x26 = done flag, x27 = pass flag, x3 (gp) = test number
  localparam int TSM_DONE_REG_DEF = 26;
  localparam int TSM_PASS_REG_DEF = 27;
  localparam int TSM_TNUM_REG_DEF = 3;

  localparam int SH_DONE = 0;
  localparam int SH_PASS = 1;
  localparam int SH_TNUM = 2;
  localparam int SH_NUM  = 3;

  function automatic logic tsm_is_terminal(tsm_state_e s);
    return s inside {TSM_PASS, TSM_FAIL, TSM_TO};
  endfunction

endpackage

// File: rtl/test_status_monitor_if.sv
// Regfile write-port snoop bundle: the core drives it (master), the monitor
// observes it (slave).
interface test_status_monitor_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;

  modport master (output rf_we, rf_waddr, rf_wdata);
  modport slave  (input  rf_we, rf_waddr, rf_wdata);
endinterface

// File: rtl/test_status_monitor_trace_buf.sv
// Circular buffer of the most recent regfile writes, read newest-first.
// Only built when TSM_TRACE_EN is defined.
`ifdef TSM_TRACE_EN
module test_status_monitor_trace_buf #(
  parameter  int XLEN   = 32,
  parameter  int REG_AW = 5,
  parameter  int DEPTH  = 8,
  localparam int IW     = $clog2(DEPTH),
  localparam int EW     = REG_AW + XLEN
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [EW-1:0] entry_i,
  input  logic [IW-1:0] idx_i,
  output logic [EW-1:0] entry_o
);

  logic [EW-1:0] mem_q [DEPTH];
  logic [IW-1:0] wptr_q;
  logic [IW-1:0] rd_ptr;

  // wptr points at the next free slot; the power-of-two depth makes the
  // subtraction wrap for free, so idx_i is implicitly taken modulo DEPTH.
  assign rd_ptr  = wptr_q - IW'(1) - idx_i;
  assign entry_o = mem_q[rd_ptr];

  // NOTE: the storage is reset on purpose: unwritten entries must read 0, and
  // at this depth a flop-based clear is cheaper than per-entry valid bits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      wptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[wptr_q] <= entry_i;
      wptr_q        <= wptr_q + IW'(1);
    end
  end

endmodule
`endif

// File: rtl/test_status_monitor.sv
// End-of-test checker for riscv_core self-test programs: snoops regfile writes,
// runs a watchdog and reports PASS/FAIL/TIMEOUT. Optional trace: TSM_TRACE_EN.
module test_status_monitor
  import test_status_monitor_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int REG_AW         = 5,
  parameter int DONE_REG       = TSM_DONE_REG_DEF,
  parameter int PASS_REG       = TSM_PASS_REG_DEF,
  parameter int TNUM_REG       = TSM_TNUM_REG_DEF,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 32
`ifdef TSM_TRACE_EN
  , parameter int TRACE_DEPTH  = 8
`endif
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic                         clr,
  test_status_monitor_if.slave         rf_if,
  output logic                         done_o,
  output logic                         pass_o,
  output logic                         fail_o,
  output logic                         timeout_o,
  output logic [XLEN-1:0]              fail_tnum_o,
  output logic [CNT_W-1:0]             cycle_cnt_o,
  output logic [CNT_W-1:0]             wr_cnt_o
`ifdef TSM_TRACE_EN
  , input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx_i,
  output logic [REG_AW+XLEN-1:0]           trace_data_o
`endif
);

  localparam int                  SETTLE_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [REG_AW-1:0]   SH_ADDR [SH_NUM] = '{REG_AW'(DONE_REG),
                                                       REG_AW'(PASS_REG),
                                                       REG_AW'(TNUM_REG)};

  tsm_state_e          state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [XLEN-1:0]     shadow_q [SH_NUM];
  logic [XLEN-1:0]     shadow_d [SH_NUM];
  logic [CNT_W-1:0]    cycle_q, cycle_d;
  logic [CNT_W-1:0]    wr_q, wr_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic                to_q, to_d;
  logic [XLEN-1:0]     tnum_q, tnum_d;

  logic            wr_valid;
  logic            done_hit;
  logic            pass_hit;
  logic [XLEN-1:0] pass_now;
  logic            to_hit;
  logic            active;

  // x0 writes are architecturally void, so they never count as seen writes.
  assign wr_valid = rf_if.rf_we && (rf_if.rf_waddr != '0);
  assign done_hit = wr_valid && (rf_if.rf_waddr == SH_ADDR[SH_DONE])
                    && (rf_if.rf_wdata == XLEN'(1));
  assign pass_hit = wr_valid && (rf_if.rf_waddr == SH_ADDR[SH_PASS]);
  // Bypass so a pass write landing on the sampling cycle itself is honoured.
  assign pass_now = pass_hit ? rf_if.rf_wdata : shadow_q[SH_PASS];
  assign to_hit   = (TIMEOUT_CYCLES != 0) && (cycle_q == TO_LAST);
  assign active   = (state_q == TSM_RUN) || (state_q == TSM_SETTLE);

  // NOTE: every always_comb target gets a default on entry; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      TSM_IDLE: if (start) state_d = TSM_RUN;
      TSM_RUN: begin
        if (done_hit) begin
          state_d  = TSM_SETTLE;
          settle_d = SETTLE_LOAD;
        end else if (to_hit) begin
          state_d = TSM_TO;
        end
      end
      TSM_SETTLE: begin
        if (settle_q == '0) state_d = (pass_now == XLEN'(1)) ? TSM_PASS : TSM_FAIL;
        else                settle_d = settle_q - SETTLE_W'(1);
      end
      default: ;
    endcase
    if (clr) begin
      state_d  = TSM_IDLE;
      settle_d = '0;
    end
  end

  always_comb begin
    for (int i = 0; i < SH_NUM; i++) begin
      shadow_d[i] = clr ? '0 : shadow_q[i];
      if (!clr && !tsm_is_terminal(state_q) && wr_valid && (rf_if.rf_waddr == SH_ADDR[i]))
        shadow_d[i] = rf_if.rf_wdata;
    end

    cycle_d = cycle_q;
    wr_d    = wr_q;
    if (clr || ((state_q == TSM_IDLE) && start)) begin
      cycle_d = '0;
      wr_d    = '0;
    end else if (active) begin
      if (cycle_q != '1)             cycle_d = cycle_q + CNT_W'(1);
      if (wr_valid && (wr_q != '1))  wr_d    = wr_q + CNT_W'(1);
    end

    // Status flags mirror the next state so they rise on the same edge the
    // FSM enters its terminal state.
    done_d = tsm_is_terminal(state_d);
    pass_d = (state_d == TSM_PASS);
    fail_d = (state_d == TSM_FAIL) || (state_d == TSM_TO);
    to_d   = (state_d == TSM_TO);
    tnum_d = tnum_q;
    if (clr)                                      tnum_d = '0;
    else if (fail_d && !tsm_is_terminal(state_q)) tnum_d = shadow_q[SH_TNUM];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= TSM_IDLE;
      settle_q <= '0;
      for (int i = 0; i < SH_NUM; i++) shadow_q[i] <= '0;
      cycle_q  <= '0;
      wr_q     <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      to_q     <= 1'b0;
      tnum_q   <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      for (int i = 0; i < SH_NUM; i++) shadow_q[i] <= shadow_d[i];
      cycle_q  <= cycle_d;
      wr_q     <= wr_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      to_q     <= to_d;
      tnum_q   <= tnum_d;
    end
  end

  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign fail_o      = fail_q;
  assign timeout_o   = to_q;
  assign fail_tnum_o = tnum_q;
  assign cycle_cnt_o = cycle_q;
  assign wr_cnt_o    = wr_q;

`ifdef TSM_TRACE_EN
  logic trace_we;

  // Recording stops once a verdict is reached so the trace shows the lead-up.
  assign trace_we = active && wr_valid && !clr;

  test_status_monitor_trace_buf #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW),
    .DEPTH  (TRACE_DEPTH)
  ) u_trace_buf (
    .clk     (clk),
    .rstn    (rstn),
    .clr_i   (clr),
    .we_i    (trace_we),
    .entry_i ({rf_if.rf_waddr, rf_if.rf_wdata}),
    .idx_i   (trace_idx_i),
    .entry_o (trace_data_o)
  );
`endif

endmodule

// File: tb/tb_test_status_monitor.sv
// Directed bench for test_status_monitor: pass/fail/settle/timeout/clr/reset
// scenarios, plus the trace buffer when TSM_TRACE_EN is defined.
module tb_test_status_monitor;

  logic clk = 1'b0;
  logic rstn, start, clr;

  test_status_monitor_if #(.XLEN(32), .REG_AW(5)) rf_bus ();

  logic        done_o, pass_o, fail_o, timeout_o;
  logic [31:0] fail_tnum_o, cycle_cnt_o, wr_cnt_o;
  logic        s_done, s_pass, s_fail, s_to;
  logic [31:0] s_tnum;
  logic [3:0]  s_cycle, s_wr;
`ifdef TSM_TRACE_EN
  logic [2:0]  trace_idx;
  logic [36:0] trace_data, s_trace_data, exp_trace;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  test_status_monitor #(.TIMEOUT_CYCLES(50)) dut (
    .clk (clk), .rstn (rstn), .start (start), .clr (clr), .rf_if (rf_bus),
    .done_o (done_o), .pass_o (pass_o), .fail_o (fail_o), .timeout_o (timeout_o),
    .fail_tnum_o (fail_tnum_o), .cycle_cnt_o (cycle_cnt_o), .wr_cnt_o (wr_cnt_o)
`ifdef TSM_TRACE_EN
    , .trace_idx_i (trace_idx), .trace_data_o (trace_data)
`endif
  );

  // Narrow counters, watchdog disabled: exercises saturation.
  test_status_monitor #(.TIMEOUT_CYCLES(0), .CNT_W(4)) dut_sat (
    .clk (clk), .rstn (rstn), .start (start), .clr (clr), .rf_if (rf_bus),
    .done_o (s_done), .pass_o (s_pass), .fail_o (s_fail), .timeout_o (s_to),
    .fail_tnum_o (s_tnum), .cycle_cnt_o (s_cycle), .wr_cnt_o (s_wr)
`ifdef TSM_TRACE_EN
    , .trace_idx_i (trace_idx), .trace_data_o (s_trace_data)
`endif
  );

  function automatic logic [3:0] flags();
    return {done_o, pass_o, fail_o, timeout_o};
  endfunction

  // Stimulus helpers: all start and end on a falling edge.
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
    rf_bus.rf_we = 1'b1; rf_bus.rf_waddr = a; rf_bus.rf_wdata = d;
    @(negedge clk);
    rf_bus.rf_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1; @(negedge clk); clr = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; clr = 1'b0;
    rf_bus.rf_we = 1'b0; rf_bus.rf_waddr = '0; rf_bus.rf_wdata = '0;
`ifdef TSM_TRACE_EN
    trace_idx = '0;
`endif
    cycles(2);
    n_checks++; if (flags() !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", flags()); else n_pass++;
    n_checks++; if (fail_tnum_o !== 32'd0) $display("FAIL reset_tnum: got %0d want 0", fail_tnum_o); else n_pass++;
    n_checks++; if (cycle_cnt_o !== 32'd0) $display("FAIL reset_cycle: got %0d want 0", cycle_cnt_o); else n_pass++;
    @(negedge clk); rstn = 1'b1;
    rf_write(5'd5, 32'd1);
    cycles(3);
    n_checks++; if (cycle_cnt_o !== 32'd0) $display("FAIL idle_cycle: got %0d want 0", cycle_cnt_o); else n_pass++;
    n_checks++; if (wr_cnt_o !== 32'd0) $display("FAIL idle_wr: got %0d want 0", wr_cnt_o); else n_pass++;
  endtask

  task automatic test_pass();
    pulse_start();
    n_checks++; if (cycle_cnt_o !== 32'd0) $display("FAIL t1_cycle_start: got %0d want 0", cycle_cnt_o); else n_pass++;
    rf_write(5'd27, 32'd1);
    rf_write(5'd26, 32'd1);
    n_checks++; if (flags() !== 4'b0000) $display("FAIL t1_settle0: got %b want 0000", flags()); else n_pass++;
    cycles(1);
    n_checks++; if (flags() !== 4'b0000) $display("FAIL t1_settle1: got %b want 0000", flags()); else n_pass++;
    cycles(1);
    n_checks++; if (flags() !== 4'b1100) $display("FAIL t1_pass: got %b want 1100", flags()); else n_pass++;
    n_checks++; if (cycle_cnt_o !== 32'd4) $display("FAIL t1_cycle: got %0d want 4", cycle_cnt_o); else n_pass++;
    n_checks++; if (wr_cnt_o !== 32'd2) $display("FAIL t1_wr: got %0d want 2", wr_cnt_o); else n_pass++;
    pulse_start();
    rf_write(5'd5, 32'd7);
    cycles(2);
    n_checks++; if (flags() !== 4'b1100) $display("FAIL t1_hold_flags: got %b want 1100", flags()); else n_pass++;
    n_checks++; if (cycle_cnt_o !== 32'd4) $display("FAIL t1_hold_cycle: got %0d want 4", cycle_cnt_o); else n_pass++;
    n_checks++; if (wr_cnt_o !== 32'd2) $display("FAIL t1_hold_wr: got %0d want 2", wr_cnt_o); else n_pass++;
  endtask

  task automatic test_clr();
    pulse_clr();
    n_checks++; if (flags() !== 4'b0000) $display("FAIL clr_flags: got %b want 0000", flags()); else n_pass++;
    n_checks++; if (cycle_cnt_o !== 32'd0) $display("FAIL clr_cycle: got %0d want 0", cycle_cnt_o); else n_pass++;
    n_checks++; if (wr_cnt_o !== 32'd0) $display("FAIL clr_wr: got %0d want 0", wr_cnt_o); else n_pass++;
    clr = 1'b1; start = 1'b1;
    @(negedge clk);
    clr = 1'b0; start = 1'b0;
    cycles(2);
    n_checks++; if (cycle_cnt_o !== 32'd0) $display("FAIL clr_start_idle: got %0d want 0", cycle_cnt_o); else n_pass++;
  endtask

  task automatic test_fail();
    pulse_start();
    rf_write(5'd3, 32'd5);
    rf_write(5'd27, 32'd0);
    rf_write(5'd26, 32'd1);
    cycles(2);
    n_checks++; if (flags() !== 4'b1010) $display("FAIL t2_flags: got %b want 1010", flags()); else n_pass++;
    n_checks++; if (fail_tnum_o !== 32'd5) $display("FAIL t2_tnum: got %0d want 5", fail_tnum_o); else n_pass++;
    rf_write(5'd3, 32'd6);
    cycles(1);
    n_checks++; if (fail_tnum_o !== 32'd5) $display("FAIL t2_tnum_frozen: got %0d want 5", fail_tnum_o); else n_pass++;
  endtask

  task automatic test_settle();
    pulse_clr(); pulse_start();
    rf_write(5'd26, 32'd1);
    rf_write(5'd27, 32'd1);
    cycles(1);
    n_checks++; if (flags() !== 4'b1100) $display("FAIL t3_late_pass: got %b want 1100", flags()); else n_pass++;
    pulse_clr(); pulse_start();
    rf_write(5'd26, 32'd1);
    cycles(1);
    rf_write(5'd27, 32'd1);
    n_checks++; if (flags() !== 4'b1100) $display("FAIL t3_bypass: got %b want 1100", flags()); else n_pass++;
    pulse_clr(); pulse_start();
    rf_write(5'd26, 32'd1);
    cycles(2);
    rf_write(5'd27, 32'd1);
    n_checks++; if (flags() !== 4'b1010) $display("FAIL t3_too_late: got %b want 1010", flags()); else n_pass++;
    pulse_clr(); pulse_start();
    rf_write(5'd26, 32'd2);
    rf_write(5'd0, 32'd9);
    cycles(3);
    n_checks++; if (flags() !== 4'b0000) $display("FAIL t3_bad_done: got %b want 0000", flags()); else n_pass++;
    n_checks++; if (cycle_cnt_o !== 32'd5) $display("FAIL t3_run_cycle: got %0d want 5", cycle_cnt_o); else n_pass++;
    n_checks++; if (wr_cnt_o !== 32'd1) $display("FAIL t3_x0_wr: got %0d want 1", wr_cnt_o); else n_pass++;
  endtask

  task automatic test_timeout();
    pulse_clr(); pulse_start();
    rf_write(5'd3, 32'd7);
    cycles(48);
    n_checks++; if (cycle_cnt_o !== 32'd49) $display("FAIL t4_cycle49: got %0d want 49", cycle_cnt_o); else n_pass++;
    n_checks++; if (flags() !== 4'b0000) $display("FAIL t4_pre_to: got %b want 0000", flags()); else n_pass++;
    cycles(1);
    n_checks++; if (flags() !== 4'b1011) $display("FAIL t4_to_flags: got %b want 1011", flags()); else n_pass++;
    n_checks++; if (fail_tnum_o !== 32'd7) $display("FAIL t4_tnum: got %0d want 7", fail_tnum_o); else n_pass++;
    cycles(5);
    n_checks++; if (cycle_cnt_o !== 32'd50) $display("FAIL t4_cycle_hold: got %0d want 50", cycle_cnt_o); else n_pass++;
    n_checks++; if (wr_cnt_o !== 32'd1) $display("FAIL t4_wr_hold: got %0d want 1", wr_cnt_o); else n_pass++;
    n_checks++; if (s_cycle !== 4'hF) $display("FAIL sat_cycle: got %0d want 15", s_cycle); else n_pass++;
    n_checks++; if ({s_done, s_pass, s_fail, s_to} !== 4'b0000) $display("FAIL sat_no_watchdog: got %b want 0000", {s_done, s_pass, s_fail, s_to}); else n_pass++;
    n_checks++; if ({s_wr, s_tnum} !== {4'd1, 32'd0}) $display("FAIL sat_wr_tnum: got %0d/%0d want 1/0", s_wr, s_tnum); else n_pass++;
  endtask

  task automatic test_mid_reset();
    pulse_clr(); pulse_start();
    rf_write(5'd3, 32'd9);
    rf_write(5'd27, 32'd1);
    n_checks++; if (cycle_cnt_o !== 32'd2) $display("FAIL t5_pre_cycle: got %0d want 2", cycle_cnt_o); else n_pass++;
    rstn = 1'b0;
    #1;
    n_checks++; if ({cycle_cnt_o, wr_cnt_o} !== 64'd0) $display("FAIL t5_async_clear: got %0d/%0d want 0/0", cycle_cnt_o, wr_cnt_o); else n_pass++;
    @(negedge clk); rstn = 1'b1;
    rf_write(5'd26, 32'd1);
    cycles(3);
    n_checks++; if (flags() !== 4'b0000) $display("FAIL t5_no_restart: got %b want 0000", flags()); else n_pass++;
    n_checks++; if (cycle_cnt_o !== 32'd0) $display("FAIL t5_idle_cycle: got %0d want 0", cycle_cnt_o); else n_pass++;
    pulse_start();
    rf_write(5'd26, 32'd1);
    cycles(2);
    n_checks++; if (flags() !== 4'b1010) $display("FAIL t5_shadow_wiped: got %b want 1010", flags()); else n_pass++;
    n_checks++; if (fail_tnum_o !== 32'd0) $display("FAIL t5_tnum_wiped: got %0d want 0", fail_tnum_o); else n_pass++;
  endtask

`ifdef TSM_TRACE_EN
  task automatic test_trace();
    pulse_clr(); pulse_start();
    for (int k = 1; k <= 10; k++) rf_write(5'(k), 32'(k));
    trace_idx = 3'd0; #1;
    exp_trace = {5'd10, 32'd10};
    n_checks++; if (trace_data !== exp_trace) $display("FAIL t6_idx0: got %h want %h", trace_data, exp_trace); else n_pass++;
    trace_idx = 3'd7; #1;
    exp_trace = {5'd3, 32'd3};
    n_checks++; if (trace_data !== exp_trace) $display("FAIL t6_idx7: got %h want %h", trace_data, exp_trace); else n_pass++;
    rf_write(5'd26, 32'd1);
    cycles(2);
    rf_write(5'd1, 32'd99);
    trace_idx = 3'd0; #1;
    exp_trace = {5'd26, 32'd1};
    n_checks++; if (trace_data !== exp_trace) $display("FAIL t6_frozen0: got %h want %h", trace_data, exp_trace); else n_pass++;
    trace_idx = 3'd1; #1;
    exp_trace = {5'd10, 32'd10};
    n_checks++; if (trace_data !== exp_trace) $display("FAIL t6_frozen1: got %h want %h", trace_data, exp_trace); else n_pass++;
    pulse_clr();
    trace_idx = 3'd0; #1;
    n_checks++; if (trace_data !== 37'd0) $display("FAIL t6_cleared: got %h want 0", trace_data); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_pass();
    test_clr();
    test_fail();
    test_settle();
    test_timeout();
    test_mid_reset();
`ifdef TSM_TRACE_EN
    test_trace();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
